dmem_arbiter: RTL

Two-master arbiter for the single-port synchronous data memory: shares the memory between the CPU load/store path (master 0) and the program/debug loader (master 1). Sits between the CPU memory-or-IO address/data path and the data memory. Accepts one access per cycle, registers the memory command, and returns read data to the issuing master with a fixed latency. Supports a loader lock for uninterrupted bulk transfers.

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 21 ++
 rtl/dmem_arbiter_arb_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: master ids, FSM encoding
// and default bus widths.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_LDR = 1'b1;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One master port of the data-memory arbiter: request/grant handshake plus
// the read-return path.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dmem_arbiter_arb_pick.sv
// Combinational two-way grant selector; the loader owns the port while
// locked, otherwise a lone request wins and contention goes to 'pref'.
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       pref,
  input  logic       locked,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (locked) begin
      gnt[MST_LDR] = req[MST_LDR];
    end else if (&req) begin
      gnt[pref] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory (CPU = m0, loader = m1).
// Define DMEM_ARB_RR_EN for round-robin contention; default is fixed CPU priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              rst,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  input  logic              m1_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e state, state_nxt;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] rvalid;
  logic       pref;
  logic       sel_ldr;
  logic       cmd_owner;

  assign req = {m1.req, m0.req};

  arb_pick u_pick (
    .req    (req),
    .pref   (pref),
    .locked (state == ST_LOCKED),
    .gnt    (gnt)
  );

  assign m0.gnt  = gnt[MST_CPU];
  assign m1.gnt  = gnt[MST_LDR];
  assign sel_ldr = gnt[MST_LDR];

`ifdef DMEM_ARB_RR_EN
  // Remember the last winner; the other master is preferred on contention.
  logic last_gnt;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      last_gnt <= MST_LDR;
    end else if (|gnt) begin
      last_gnt <= sel_ldr;
    end
  end

  assign pref = ~last_gnt;
`else
  assign pref = MST_CPU;
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= ST_OPEN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OPEN:   if (gnt[MST_LDR] && m1_lock) state_nxt = ST_LOCKED;
      ST_LOCKED: if (!m1_lock) state_nxt = ST_OPEN;
      default:   state_nxt = ST_OPEN;
    endcase
  end

  // Address and data hold their last value between accesses.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_owner <= MST_CPU;
    end else begin
      mem_en    <= |gnt;
      mem_we    <= (|gnt) & (sel_ldr ? m1.we : m0.we);
      cmd_owner <= sel_ldr;
      if (|gnt) begin
        mem_addr  <= sel_ldr ? m1.addr  : m0.addr;
        mem_wdata <= sel_ldr ? m1.wdata : m0.wdata;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rvalid <= 2'b00;
    end else begin
      rvalid[MST_CPU] <= mem_en & ~mem_we & (cmd_owner == MST_CPU);
      rvalid[MST_LDR] <= mem_en & ~mem_we & (cmd_owner == MST_LDR);
    end
  end

  assign m0.rvalid = rvalid[MST_CPU];
  assign m1.rvalid = rvalid[MST_LDR];
  assign m0.rdata  = mem_rdata;
  assign m1.rdata  = mem_rdata;
  assign busy      = mem_en | (|rvalid);

endmodule
